// File: rtl/ts_audio_mixer.sv
// TurboSound audio back end: captures both AY channels and the beeper, mixes them
// to stereo 10-bit PCM, applies a soft-mute gain ramp and drives 1-bit sigma-delta DACs.
module ts_audio_mixer #(
  parameter logic [9:0]  BEEP_LEVEL = 10'd128,
  parameter int unsigned RAMP_SHIFT = 8
) (
  input  logic       clk7,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [7:0] ay1,
  input  logic [7:0] ay2,
  input  logic       beeper,
  input  logic [1:0] mode,
  input  logic       mute,
  output logic [9:0] pcm_l,
  output logic [9:0] pcm_r,
  output logic       dac_l,
  output logic       dac_r,
  output logic       muted
);

  logic [7:0]            ay1_q;
  logic [7:0]            ay2_q;
  logic                  beep_q;
  logic [1:0]            mode_q;
  logic [9:0]            mix_l;
  logic [9:0]            mix_r;
  logic [4:0]            gain;
  logic [RAMP_SHIFT-1:0] presc;
  logic                  tick;
  logic [10:0]           acc_l;
  logic [10:0]           acc_r;

  logic [10:0] beep_add;
  logic [10:0] ay1_x2;
  logic [10:0] ay2_x2;
  logic [10:0] ay_sum;
  logic [10:0] sum_l;
  logic [10:0] sum_r;
  logic [14:0] prod_l;
  logic [14:0] prod_r;
  logic [10:0] sd_l;
  logic [10:0] sd_r;

  function automatic logic [9:0] saturate(input logic [10:0] s);
    return (s > 11'd1023) ? 10'h3FF : s[9:0];
  endfunction

  always_ff @(posedge clk7) begin
    if (reset) begin
      ay1_q  <= 8'd0;
      ay2_q  <= 8'd0;
      beep_q <= 1'b0;
      mode_q <= 2'd0;
    end else if (sample_en) begin
      ay1_q  <= ay1;
      ay2_q  <= ay2;
      beep_q <= beeper;
      mode_q <= mode;
    end
  end

  assign beep_add = beep_q ? {1'b0, BEEP_LEVEL} : 11'd0;
  assign ay1_x2   = {2'b00, ay1_q, 1'b0};
  assign ay2_x2   = {2'b00, ay2_q, 1'b0};
  assign ay_sum   = {3'b000, ay1_q} + {3'b000, ay2_q};

  always_comb begin
    sum_l = 11'd0;
    sum_r = 11'd0;
    case (mode_q)
      2'd0: begin
        sum_l = ay_sum + beep_add;
        sum_r = ay_sum + beep_add;
      end
      2'd1: begin
        sum_l = ay1_x2 + beep_add;
        sum_r = ay2_x2 + beep_add;
      end
      2'd2: begin
        sum_l = ay2_x2 + beep_add;
        sum_r = ay1_x2 + beep_add;
      end
      default: begin
        sum_l = ay1_x2 + beep_add;
        sum_r = ay1_x2 + beep_add;
      end
    endcase
  end

  // Gain is at most 16, so the scaled product never exceeds the mix value.
  assign prod_l = {5'd0, mix_l} * {10'd0, gain};
  assign prod_r = {5'd0, mix_r} * {10'd0, gain};

  always_ff @(posedge clk7) begin
    if (reset) begin
      mix_l <= 10'd0;
      mix_r <= 10'd0;
      pcm_l <= 10'd0;
      pcm_r <= 10'd0;
    end else begin
      mix_l <= saturate(sum_l);
      mix_r <= saturate(sum_r);
      pcm_l <= prod_l[13:4];
      pcm_r <= prod_r[13:4];
    end
  end

  // Tick fires on the edge where the prescaler wraps back to zero.
  assign tick = &presc;

  always_ff @(posedge clk7) begin
    if (reset) begin
      presc <= '0;
      gain  <= 5'd0;
      muted <= 1'b1;
    end else begin
      presc <= presc + 1'b1;
      muted <= (gain == 5'd0);
      if (tick) begin
        if (mute && gain != 5'd0)
          gain <= gain - 5'd1;
        else if (!mute && gain != 5'd16)
          gain <= gain + 5'd1;
      end
    end
  end

  assign sd_l = {1'b0, acc_l[9:0]} + {1'b0, pcm_l};
  assign sd_r = {1'b0, acc_r[9:0]} + {1'b0, pcm_r};

  // First-order modulator: the carry out of the 10-bit accumulator is the bitstream.
  always_ff @(posedge clk7) begin
    if (reset) begin
      acc_l <= 11'd0;
      acc_r <= 11'd0;
      dac_l <= 1'b0;
      dac_r <= 1'b0;
    end else begin
      acc_l <= sd_l;
      acc_r <= sd_r;
      dac_l <= sd_l[10];
      dac_r <= sd_r[10];
    end
  end

endmodule

// File: tb/tb_ts_audio_mixer.sv
// Directed bench for ts_audio_mixer: fade-in, mixing modes, latency, sigma-delta
// density, soft mute reversal and saturation, with a second instance at BEEP_LEVEL=513.
module tb_ts_audio_mixer;

  logic       clk7 = 1'b0;
  logic       reset;
  logic       sample_en;
  logic [7:0] ay1;
  logic [7:0] ay2;
  logic       beeper;
  logic [1:0] mode;
  logic       mute;
  logic [9:0] pcm_l, pcm_r, pcm_l2, pcm_r2;
  logic       dac_l, dac_r, dac_l2, dac_r2;
  logic       muted, muted2;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk7 = ~clk7;

  ts_audio_mixer #(.BEEP_LEVEL(10'd128), .RAMP_SHIFT(8)) dut (
    .clk7(clk7), .reset(reset), .sample_en(sample_en), .ay1(ay1), .ay2(ay2),
    .beeper(beeper), .mode(mode), .mute(mute), .pcm_l(pcm_l), .pcm_r(pcm_r),
    .dac_l(dac_l), .dac_r(dac_r), .muted(muted)
  );

  ts_audio_mixer #(.BEEP_LEVEL(10'd513), .RAMP_SHIFT(8)) dutSat (
    .clk7(clk7), .reset(reset), .sample_en(sample_en), .ay1(ay1), .ay2(ay2),
    .beeper(beeper), .mode(mode), .mute(mute), .pcm_l(pcm_l2), .pcm_r(pcm_r2),
    .dac_l(dac_l2), .dac_r(dac_r2), .muted(muted2)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk7);
  endtask

  // Inputs change on the falling edge; with strobe set, exactly one rising edge captures.
  task automatic applyStimulus(input logic [7:0] a1, input logic [7:0] a2,
                               input logic bp, input logic [1:0] md, input logic strobe);
    ay1 = a1;
    ay2 = a2;
    beeper = bp;
    mode = md;
    if (strobe) begin
      sample_en = 1'b1;
      waitClocks(1);
      sample_en = 1'b0;
    end
  endtask

  task automatic countOnes(input int n, output int onesL, output int onesL2);
    onesL = 0;
    onesL2 = 0;
    for (int i = 0; i < n; i++) begin
      waitClocks(1);
      onesL += int'(dac_l);
      onesL2 += int'(dac_l2);
    end
  endtask

  initial begin
    int onesA, onesB;
    int waited;
    reset = 1'b1;
    sample_en = 1'b0;
    ay1 = 8'd0;
    ay2 = 8'd0;
    beeper = 1'b0;
    mode = 2'd0;
    mute = 1'b0;

    waitClocks(2);
    checkOutput("rst_pcm_l", pcm_l, 0);
    checkOutput("rst_pcm_r", pcm_r, 0);
    checkOutput("rst_dac_l", dac_l, 0);
    checkOutput("rst_dac_r", dac_r, 0);
    checkOutput("rst_muted", muted, 1);
    reset = 1'b0;

    // Strobe on the first edge after release; ticks fall on edges 256, 512, ...
    applyStimulus(8'd200, 8'd100, 1'b1, 2'd0, 1'b1);
    waitClocks(255);
    checkOutput("fade_muted_at_tick", muted, 1);
    checkOutput("fade_pcm_g0", pcm_l, 0);
    waitClocks(1);
    checkOutput("fade_muted_fall", muted, 0);
    checkOutput("fade_pcm_g1", pcm_l, 26);
    waitClocks(3839);
    checkOutput("fade_pcm_g15", pcm_l, 401);
    waitClocks(1);
    checkOutput("mono_pcm_l", pcm_l, 428);
    checkOutput("mono_pcm_r", pcm_r, 428);

    applyStimulus(8'd7, 8'd9, 1'b0, 2'd1, 1'b0);
    waitClocks(4);
    checkOutput("mono_hold_l", pcm_l, 428);
    checkOutput("mono_hold_r", pcm_r, 428);

    applyStimulus(8'd255, 8'd0, 1'b0, 2'd1, 1'b1);
    checkOutput("lat_k_l", pcm_l, 428);
    waitClocks(1);
    checkOutput("lat_k1_l", pcm_l, 428);
    waitClocks(1);
    checkOutput("stereo_l", pcm_l, 510);
    checkOutput("stereo_r", pcm_r, 0);

    applyStimulus(8'd255, 8'd0, 1'b0, 2'd2, 1'b0);
    waitClocks(4);
    checkOutput("mode_nostrobe_l", pcm_l, 510);
    checkOutput("mode_nostrobe_r", pcm_r, 0);
    applyStimulus(8'd255, 8'd0, 1'b0, 2'd2, 1'b1);
    waitClocks(2);
    checkOutput("swap_l", pcm_l, 0);
    checkOutput("swap_r", pcm_r, 510);
    applyStimulus(8'd255, 8'd0, 1'b0, 2'd3, 1'b1);
    waitClocks(2);
    checkOutput("single_l", pcm_l, 510);
    checkOutput("single_r", pcm_r, 510);

    applyStimulus(8'd200, 8'd184, 1'b1, 2'd0, 1'b1);
    waitClocks(4);
    checkOutput("sd_pcm512", pcm_l, 512);
    countOnes(1024, onesA, onesB);
    checkOutput("sd_ones512", onesA, 512);

    applyStimulus(8'd0, 8'd0, 1'b0, 2'd0, 1'b1);
    waitClocks(4);
    countOnes(1024, onesA, onesB);
    checkOutput("sd_ones0", onesA, 0);

    applyStimulus(8'd255, 8'd0, 1'b1, 2'd1, 1'b1);
    waitClocks(4);
    checkOutput("sat_pcm_l", pcm_l2, 1023);
    checkOutput("sat_pcm_r", pcm_r2, 513);
    checkOutput("beep128_pcm_l", pcm_l, 638);
    countOnes(1024, onesA, onesB);
    checkOutput("sd_ones1023", onesB, 1023);

    // Soft mute on a 400 mix: pcm = 25 * gain.
    applyStimulus(8'd200, 8'd100, 1'b0, 2'd1, 1'b1);
    waitClocks(4);
    checkOutput("mute_start_l", pcm_l, 400);
    checkOutput("mute_start_r", pcm_r, 200);
    mute = 1'b1;
    waited = 0;
    while (pcm_l == 10'd400 && waited < 300) begin
      waitClocks(1);
      waited++;
    end
    checkOutput("mute_tick_found", int'(waited < 300), 1);
    checkOutput("mute_g15", pcm_l, 375);
    for (int g = 14; g >= 0; g--) begin
      waitClocks(255);
      checkOutput("mute_pre", pcm_l, 25 * (g + 1));
      waitClocks(1);
      checkOutput("mute_step", pcm_l, 25 * g);
      if (g == 8) checkOutput("mute_g8", pcm_l, 200);
      if (g == 1) checkOutput("muted_g1", muted, 0);
    end
    checkOutput("muted_g0", muted, 1);

    mute = 1'b0;
    for (int g = 1; g <= 6; g++) begin
      waitClocks(256);
      checkOutput("unmute_step", pcm_l, 25 * g);
    end
    mute = 1'b1;
    waitClocks(256);
    checkOutput("remute_g5", pcm_l, 125);
    waitClocks(256);
    checkOutput("remute_g4", pcm_l, 100);
    mute = 1'b0;
    waitClocks(256);
    checkOutput("reverse_g5", pcm_l, 125);

    reset = 1'b1;
    waitClocks(2);
    checkOutput("rst2_pcm_l", pcm_l, 0);
    checkOutput("rst2_dac_l", dac_l, 0);
    checkOutput("rst2_muted", muted, 1);
    reset = 1'b0;
    applyStimulus(8'd200, 8'd100, 1'b0, 2'd1, 1'b1);
    waitClocks(10);
    checkOutput("rst2_gain0_pcm", pcm_l, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ts_audio_mixer.md
# ts_audio_mixer

Downstream audio stage for the dual-AY TurboSound block. Samples the two 8-bit AY outputs and the beeper, mixes them into left/right 10-bit PCM according to a stereo mode, applies a click-free soft-mute gain ramp, and drives two first-order sigma-delta 1-bit DAC outputs for the board's audio pins. All logic runs on the 7 MHz system clock.

## Interface
- `BEEP_LEVEL`, default 10'd128 — amount added to both channels while `beeper`=1; legal range 0..513.
- `RAMP_SHIFT`, default 8 — gain ramp advances one step every 2^RAMP_SHIFT clocks.

- `clk7` in 1 — system clock. All state changes on its rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `sample_en` in 1 — capture strobe for `ay1`, `ay2`, `beeper` and `mode`.
- `ay1` in 8 — AY #1 mixed audio.
- `ay2` in 8 — AY #2 mixed audio.
- `beeper` in 1 — ULA beeper/EAR level.
- `mode` in 2 — 0 mono, 1 stereo (AY1 left), 2 stereo swapped, 3 single-AY.
- `mute` in 1 — 1 ramps gain to 0; 0 ramps gain to 16.
- `pcm_l` out 10 — scaled left PCM.
- `pcm_r` out 10 — scaled right PCM.
- `dac_l` out 1 — left sigma-delta bitstream.
- `dac_r` out 1 — right sigma-delta bitstream.
- `muted` out 1 — high while gain == 0.

## Operation
- **Capture stage.** On an edge with `sample_en`=1, register `ay1`, `ay2`, `beeper` and `mode`. Otherwise the captured values hold. Input changes between strobes are ignored, and a new `mode` takes effect only at the next strobe.
- **Mix stage.** Registered every clock from the captured values. Let b = `beeper` ? BEEP_LEVEL : 0.
  - mode 0: L = R = ay1 + ay2 + b.
  - mode 1: L = 2·ay1 + b, R = 2·ay2 + b.
  - mode 2: L = 2·ay2 + b, R = 2·ay1 + b.
  - mode 3: L = R = 2·ay1 + b.
  - Sums are 11 bits wide and saturate to 1023.
- **Gain stage.** Registered every clock: pcm = (mix × gain) >> 4, with a 15-bit product, truncated and kept to 10 bits. Gain is a 5-bit value in 0..16, so pcm ≤ mix.
- **Gain ramp.** A free-running RAMP_SHIFT-bit prescaler produces a tick when it wraps to 0.
  - On a tick: if `mute`=1 and gain > 0, gain decrements. If `mute`=0 and gain < 16, gain increments.
  - Gain holds at the 0 and 16 limits.
  - Toggling `mute` mid-ramp reverses direction at the next tick.
- **Sigma-delta.** One 11-bit accumulator per channel, updated every clock: acc ← {0, acc[9:0]} + pcm.
  - `dac` is registered as the carry bit acc[10] of that sum.
  - Density of ones = pcm/1024. pcm=0 gives constant 0.
- `muted` is registered and equals (gain == 0).

## Timing
- **Reset values.** Capture regs, mix regs, pcm_l, pcm_r, accumulators, dac_l, dac_r, gain and prescaler are all 0. `muted`=1. Reset overrides `sample_en` and the ramp.
- **Latency.** Strobe at edge k → mix regs updated at k+1 → `pcm_*` updated at k+2 → first `dac_*` bit using the new pcm at k+3.
- **Gain timing.** Gain changes at a tick edge t; `pcm_*` reflects the new gain at t+1.
- **Full ramp time.** From gain 0 to 16 (or 16 to 0) takes 16 ticks = 16·2^RAMP_SHIFT clocks. The first tick after reset occurs at clock 2^RAMP_SHIFT.
- **No handshake.** `sample_en` may be held high continuously, which captures every clock.
- **Reset mid-ramp or mid-sample.** All state returns to reset values. The fade-in restarts from gain 0.

## Test plan
- **Reset and fade-in:** assert `reset` for 2 clocks, with `mute`=0 and RAMP_SHIFT=8 → all outputs 0, `muted`=1. Gain reaches 16 exactly 4096 clocks after reset release. `muted` falls 1 clock after the first tick.
- **Mono mix:** gain 16, mode 0, ay1=200, ay2=100, beeper=1, BEEP_LEVEL=128, one strobe → pcm_l = pcm_r = 428 exactly 2 clocks after the strobe edge. Holds when the inputs change without a strobe.
- **Stereo and swap:** ay1=255, ay2=0, beeper=0.
  - mode 1 → pcm_l=510, pcm_r=0.
  - Change mode to 2 without a strobe → no change.
  - After a strobe → pcm_l=0, pcm_r=510.
  - mode 3 → both 510.
- **Sigma-delta density (gain 16):**
  - pcm=512 → dac alternates 0,1,… giving exactly 512 ones per 1024 clocks.
  - pcm=0 → all 0.
  - pcm=1023 → 1023 ones per 1024 clocks.
- **Soft mute:** mix=400, gain 16.
  - Assert `mute` → pcm steps 375, 350, … (one step per tick). At gain 8, pcm=200.
  - `muted`=1 and pcm=0 after 16 ticks.
  - Deassert `mute` at gain 4 → next tick gives gain 5, pcm=125.
- **Saturation:** BEEP_LEVEL=513 with mode 1, ay1=255, beeper=1 → pcm_l=1023 with no wrap.
